// File: rtl/sap_core_p.sv
// Parametrised SAP-style accumulator core: variable-length T-state sequencer,
// ADD/SUB with Z/C flags, conditional branches and a RAM programming port.
module sap_core_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr_,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic [2:0]        t_state,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int DEPTH = 1 << ADDR_W;

    state_t              state_r, state_nxt_s;
    logic [2:0]          t_r, t_nxt_s, last_t_s;
    logic [ADDR_W-1:0]   pc_r, mar_r, ir_arg_r;
    logic [3:0]          ir_op_r;
    logic [DATA_W-1:0]   a_r, b_r, out_r;
    logic                z_r, c_r, out_valid_r;
    logic [DATA_W-1:0]   ram_r [DEPTH];

    logic [DATA_W-1:0]   ram_q_s, op_ext_s, b_eff_s, bus_s;
    logic [DATA_W:0]     sum_s;
    logic                sub_s, start_s, prog_wr_s;
    logic                ld_mar_pc_s, inc_pc_s, ld_ir_s, ld_mar_op_s, ld_a_mem_s, ld_b_mem_s;
    logic                ld_a_alu_s, ld_a_imm_s, ld_pc_op_s, ld_out_s, sta_wr_s;

    assign ram_q_s   = ram_r[mar_r];
    assign op_ext_s  = {{(DATA_W-ADDR_W){1'b0}}, ir_arg_r};
    assign sub_s     = (ir_op_r == OP_SUB);
    // SUB is A + ~B + 1, so the adder carry-out doubles as the A >= B flag
    assign b_eff_s   = sub_s ? ~b_r : b_r;
    assign sum_s     = {1'b0, a_r} + {1'b0, b_eff_s} + {{DATA_W{1'b0}}, sub_s};
    assign prog_wr_s = prog_we && (state_r != ST_RUN);

    // Number of the final T-state for the instruction held in IR
    always_comb begin
        case (ir_op_r)
            OP_LDA, OP_STA: last_t_s = 3'd5;
            OP_ADD, OP_SUB: last_t_s = 3'd6;
            default:        last_t_s = 3'd4;
        endcase
    end

    // Top-level state and T-state register
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_r <= ST_LOAD;
            t_r     <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            t_r     <= t_nxt_s;
        end
    end

    // Next-state logic: start, T-state sequencing and halt
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = t_r;
        start_s     = 1'b0;
        case (state_r)
            ST_LOAD, ST_HALT: begin
                if (run) begin
                    state_nxt_s = ST_RUN;
                    t_nxt_s     = 3'd1;
                    start_s     = 1'b1;
                end else begin
                    t_nxt_s     = 3'd0;
                end
            end
            ST_RUN: begin
                if ((t_r == 3'd4) && (ir_op_r == OP_HLT)) begin
                    state_nxt_s = ST_HALT;
                    t_nxt_s     = 3'd0;
                end else if (t_r >= last_t_s) begin
                    t_nxt_s     = 3'd1;
                end else begin
                    t_nxt_s     = t_r + 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                t_nxt_s     = 3'd0;
            end
        endcase
    end

    // Micro-operation decode from T-state and opcode
    always_comb begin
        ld_mar_pc_s = 1'b0;
        inc_pc_s    = 1'b0;
        ld_ir_s     = 1'b0;
        ld_mar_op_s = 1'b0;
        ld_a_mem_s  = 1'b0;
        ld_b_mem_s  = 1'b0;
        ld_a_alu_s  = 1'b0;
        ld_a_imm_s  = 1'b0;
        ld_pc_op_s  = 1'b0;
        ld_out_s    = 1'b0;
        sta_wr_s    = 1'b0;
        if (state_r == ST_RUN) begin
            case (t_r)
                3'd1: ld_mar_pc_s = 1'b1;
                3'd2: inc_pc_s    = 1'b1;
                3'd3: ld_ir_s     = 1'b1;
                3'd4: begin
                    case (ir_op_r)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: ld_mar_op_s = 1'b1;
                        OP_LDI:  ld_a_imm_s = 1'b1;
                        OP_JMP:  ld_pc_op_s = 1'b1;
                        OP_JC:   ld_pc_op_s = c_r;
                        OP_JZ:   ld_pc_op_s = z_r;
                        OP_OUT:  ld_out_s   = 1'b1;
                        default: ld_out_s   = 1'b0;
                    endcase
                end
                3'd5: begin
                    case (ir_op_r)
                        OP_LDA:         ld_a_mem_s = 1'b1;
                        OP_ADD, OP_SUB: ld_b_mem_s = 1'b1;
                        OP_STA:         sta_wr_s   = 1'b1;
                        default:        sta_wr_s   = 1'b0;
                    endcase
                end
                3'd6: ld_a_alu_s = sub_s || (ir_op_r == OP_ADD);
                default: ld_ir_s = 1'b0;
            endcase
        end else begin
            ld_ir_s = 1'b0;
        end
    end

    // W-bus source select; idle cycles (T2, branch not taken, NOP) read as zero
    always_comb begin
        bus_s = {DATA_W{1'b0}};
        if (ld_mar_pc_s) begin
            bus_s = {{(DATA_W-ADDR_W){1'b0}}, pc_r};
        end else if (ld_ir_s || ld_a_mem_s || ld_b_mem_s) begin
            bus_s = ram_q_s;
        end else if (ld_mar_op_s || ld_a_imm_s || ld_pc_op_s) begin
            bus_s = op_ext_s;
        end else if (ld_out_s || sta_wr_s) begin
            bus_s = a_r;
        end else if (ld_a_alu_s) begin
            bus_s = sum_s[DATA_W-1:0];
        end else begin
            bus_s = {DATA_W{1'b0}};
        end
    end

    // Datapath registers; a restart clears everything except RAM and out_data
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            pc_r        <= {ADDR_W{1'b0}};
            mar_r       <= {ADDR_W{1'b0}};
            ir_op_r     <= 4'h0;
            ir_arg_r    <= {ADDR_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            out_r       <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (start_s) begin
            pc_r        <= {ADDR_W{1'b0}};
            mar_r       <= {ADDR_W{1'b0}};
            ir_op_r     <= 4'h0;
            ir_arg_r    <= {ADDR_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= ld_out_s;
            if (ld_mar_pc_s) mar_r <= pc_r;
            else if (ld_mar_op_s) mar_r <= ir_arg_r;
            if (inc_pc_s) pc_r <= pc_r + ADDR_W'(1);
            else if (ld_pc_op_s) pc_r <= ir_arg_r;
            if (ld_ir_s) begin
                ir_op_r  <= ram_q_s[DATA_W-1 -: 4];
                ir_arg_r <= ram_q_s[ADDR_W-1:0];
            end
            if (ld_a_mem_s) a_r <= ram_q_s;
            else if (ld_a_imm_s) a_r <= op_ext_s;
            else if (ld_a_alu_s) a_r <= sum_s[DATA_W-1:0];
            if (ld_b_mem_s) b_r <= ram_q_s;
            if (ld_a_alu_s) begin
                c_r <= sum_s[DATA_W];
                z_r <= (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
            end
            if (ld_out_s) out_r <= a_r;
        end
    end

    // Program RAM: programming port when idle/halted, STA write during RUN
    always_ff @(posedge clk) begin
        if (prog_wr_s) begin
            ram_r[prog_addr] <= prog_data;
        end else if (sta_wr_s) begin
            ram_r[mar_r] <= a_r;
        end
    end

    assign out_data  = out_r;
    assign out_valid = out_valid_r;
    assign bus       = bus_s;
    assign pc        = pc_r;
    assign acc       = a_r;
    assign t_state   = t_r;
    assign busy      = (state_r == ST_RUN);
    assign halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_sap_core_p.sv
// Bench for sap_core_p: directed and random programs on an 8/4 and a 12/8 instance,
// compared against an instruction-level interpreter of the ISA.
module tb_sap_core_p;

    logic        clk = 1'b0;
    logic        clr_ = 1'b0;
    logic        prog_we = 1'b0;
    logic        run = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  prog_addr = 8'h00;
    logic [11:0] prog_data = 12'h000;

    logic [7:0]  out_a, bus_a, acc_a;
    logic [3:0]  pc_a;
    logic [2:0]  t_a;
    logic        val_a, busy_a, halt_a;
    logic [11:0] out_b, bus_b, acc_b;
    logic [7:0]  pc_b;
    logic [2:0]  t_b;
    logic        val_b, busy_b, halt_b;

    logic [11:0] o_out, o_bus, o_acc;
    logic [7:0]  o_pc;
    logic [2:0]  o_t;
    logic        o_val, o_busy, o_halt;

    int n_vec = 0;
    int n_err = 0;
    int m_init [256];
    int m_mem  [256];
    int m_outs [$];
    int m_acc, m_pc, m_cycles;
    bit m_halted;
    logic [11:0] got [$];
    int r_cnt;

    always #5 clk = ~clk;

    sap_core_p #(.DATA_W(8), .ADDR_W(4)) dut_a (
        .clk(clk), .clr_(clr_), .prog_we(prog_we & ~sel), .prog_addr(prog_addr[3:0]),
        .prog_data(prog_data[7:0]), .run(run & ~sel), .out_data(out_a), .out_valid(val_a),
        .bus(bus_a), .pc(pc_a), .acc(acc_a), .t_state(t_a), .busy(busy_a), .halted(halt_a)
    );

    sap_core_p #(.DATA_W(12), .ADDR_W(8)) dut_b (
        .clk(clk), .clr_(clr_), .prog_we(prog_we & sel), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run & sel), .out_data(out_b), .out_valid(val_b),
        .bus(bus_b), .pc(pc_b), .acc(acc_b), .t_state(t_b), .busy(busy_b), .halted(halt_b)
    );

    assign o_out  = sel ? out_b : {4'h0, out_a};
    assign o_bus  = sel ? bus_b : {4'h0, bus_a};
    assign o_acc  = sel ? acc_b : {4'h0, acc_a};
    assign o_pc   = sel ? pc_b  : {4'h0, pc_a};
    assign o_t    = sel ? t_b   : t_a;
    assign o_val  = sel ? val_b : val_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_halt = sel ? halt_b : halt_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ISA interpreter: whole instructions at a time, cycle cost per opcode
    task automatic model_exec(input int dw, input int aw, input int budget);
        int dep = 1 << aw;
        int mask = (1 << dw) - 1;
        int pcm = 0, a = 0, cyc = 0, w, op, opd, len, v;
        bit z = 1'b0, c = 1'b0;
        for (int i = 0; i < dep; i++) m_mem[i] = m_init[i];
        m_outs.delete();
        m_halted = 1'b0;
        while (!m_halted) begin
            w   = m_mem[pcm];
            op  = (w >> (dw - 4)) & 15;
            opd = w % dep;
            len = (op == 1 || op == 4) ? 5 : (op == 2 || op == 3) ? 6 : 4;
            if (cyc + len > budget) break;
            cyc += len;
            pcm = (pcm + 1) % dep;
            case (op)
                1: a = m_mem[opd];
                2: begin v = a + m_mem[opd]; c = (v > mask); a = v & mask; z = (a == 0); end
                3: begin v = m_mem[opd]; c = (a >= v); a = (a - v) & mask; z = (a == 0); end
                4: m_mem[opd] = a;
                5: a = opd;
                6: pcm = opd;
                7: if (c) pcm = opd;
                8: if (z) pcm = opd;
                14: m_outs.push_back(a);
                15: m_halted = 1'b1;
                default: ;
            endcase
        end
        m_acc = a;
        m_pc = pcm;
        m_cycles = cyc;
    endtask

    task automatic write_word(input int addr, input int data);
        prog_addr = addr[7:0];
        prog_data = data[11:0];
        prog_we = 1'b1;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic clear_init();
        for (int i = 0; i < 256; i++) m_init[i] = 0;
    endtask

    task automatic do_reset();
        #2 clr_ = 1'b0;
        @(posedge clk); #3;
        clr_ = 1'b1;
    endtask

    task automatic start_and_wait(input int budget);
        got.delete();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        check("start_t_state", {29'd0, o_t}, 32'd1);
        check("start_busy", {31'd0, o_busy}, 32'd1);
        r_cnt = 0;
        while (!o_halt && r_cnt < budget) begin
            @(posedge clk); #1;
            r_cnt++;
            if (o_val) got.push_back(o_out);
        end
    endtask

    task automatic run_and_check(input string tag, input int budget);
        int dw = sel ? 12 : 8;
        int aw = sel ? 8 : 4;
        model_exec(dw, aw, budget);
        for (int i = 0; i < (1 << aw); i++) write_word(i, m_init[i]);
        start_and_wait(budget);
        check({tag, " halted"}, {31'd0, o_halt}, {31'd0, m_halted});
        if (m_halted) begin
            check({tag, " cycles"}, r_cnt, m_cycles);
            check({tag, " acc"}, {20'd0, o_acc}, m_acc);
            check({tag, " pc"}, {24'd0, o_pc}, m_pc);
        end
        check({tag, " n_out"}, got.size(), m_outs.size());
        for (int i = 0; i < got.size() && i < m_outs.size(); i++)
            check($sformatf("%s out%0d", tag, i), {20'd0, got[i]}, m_outs[i]);
        if (!o_halt) do_reset();
    endtask

    initial begin
        #1;
        check("rst out_data", {20'd0, o_out}, 32'd0);
        check("rst flags", {28'd0, o_val, o_busy, o_halt, 1'b0}, 32'd0);
        check("rst pc_acc_t", {9'd0, o_pc, o_acc, o_t}, 32'd0);
        check("rst bus", {20'd0, o_bus}, 32'd0);
        #11 clr_ = 1'b1;

        // classic SAP-1 program
        clear_init();
        m_init[0] = 'h19; m_init[1] = 'h2A; m_init[2] = 'h3B; m_init[3] = 'hE0; m_init[4] = 'hF0;
        m_init[9] = 'h10; m_init[10] = 'h14; m_init[11] = 'h18;
        run_and_check("classic", 200);
        check("classic n_pulse", got.size(), 32'd1);
        if (got.size() > 0) check("classic value", {20'd0, got[0]}, 32'h0C);
        check("classic 25cyc", r_cnt, 32'd25);
        check("classic out_reg", {20'd0, o_out}, 32'h0C);

        // 0xFF + 1: carry and zero, both branches taken
        clear_init();
        m_init[0] = 'h1C; m_init[1] = 'h2D; m_init[2] = 'h74; m_init[3] = 'hF0;
        m_init[4] = 'h86; m_init[5] = 'hF0; m_init[6] = 'hE0; m_init[7] = 'hF0;
        m_init[12] = 'hFF; m_init[13] = 'h01;
        run_and_check("carry_zero", 200);
        check("cz acc", {20'd0, o_acc}, 32'h00);
        check("cz branches", {24'd0, o_pc}, 32'd8);

        // 5 - 7: no borrow-free, nonzero, falls through both branches
        clear_init();
        m_init[0] = 'h1C; m_init[1] = 'h3D; m_init[2] = 'h75; m_init[3] = 'h85;
        m_init[4] = 'hE0; m_init[5] = 'hF0; m_init[12] = 'h05; m_init[13] = 'h07;
        run_and_check("sub_neg", 200);
        check("sub_neg acc", {20'd0, o_acc}, 32'hFE);
        check("sub_neg n_out", got.size(), 32'd1);

        // countdown loop 3 -> 2,1,0
        clear_init();
        m_init[0] = 'h53; m_init[1] = 'h37; m_init[2] = 'hE0; m_init[3] = 'h85;
        m_init[4] = 'h61; m_init[5] = 'hF0; m_init[7] = 'h01;
        run_and_check("countdown", 300);
        check("countdown n_out", got.size(), 32'd3);
        if (got.size() == 3) check("countdown seq", {8'd0, got[0], got[1], got[2]}, {8'd0, 12'd2, 12'd1, 12'd0});

        // LDI/STA into word 15, then execute it as NOP and wrap PC to 0
        clear_init();
        m_init[0] = 'h78; m_init[1] = 'h57; m_init[2] = 'h4F; m_init[3] = 'h1F; m_init[4] = 'hE0;
        m_init[5] = 'h2E; m_init[6] = 'h6F; m_init[8] = 'hE0; m_init[9] = 'hF0;
        m_init[14] = 'hFF; m_init[15] = 'hA5;
        run_and_check("sta_wrap", 300);
        if (got.size() == 2) check("sta_wrap seq", {8'd0, got[0], got[1]}, {8'd0, 12'd7, 12'd6});
        else check("sta_wrap n_out", got.size(), 32'd2);

        // reset during STA T5 must abort the write
        clear_init();
        m_init[0] = 'h59; m_init[1] = 'h4C; m_init[2] = 'hF0; m_init[12] = 'h33;
        for (int i = 0; i < 16; i++) write_word(i, m_init[i]);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        r_cnt = 0;
        while (o_t != 3'd5 && r_cnt < 20) begin
            @(posedge clk); #1;
            r_cnt++;
        end
        check("rst reach T5", {29'd0, o_t}, 32'd5);
        clr_ = 1'b0;
        #1;
        check("midrst out_data", {20'd0, o_out}, 32'd0);
        check("midrst flags", {29'd0, o_val, o_busy, o_halt}, 32'd0);
        check("midrst pc_acc_t", {9'd0, o_pc, o_acc, o_t}, 32'd0);
        check("midrst bus", {20'd0, o_bus}, 32'd0);
        @(posedge clk); #3;
        clr_ = 1'b1;
        write_word(0, 'h1C);
        write_word(1, 'hE0);
        write_word(2, 'hF0);
        start_and_wait(50);
        check("midrst halted", {31'd0, o_halt}, 32'd1);
        check("midrst n_out", got.size(), 32'd1);
        if (got.size() > 0) check("midrst ram kept", {20'd0, got[0]}, 32'h33);

        // random programs, 8/4 instance
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 16; i++)
                m_init[i] = ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
            run_and_check($sformatf("rand8_%0d", p), 300);
        end

        // 12/8 instance: classic program relocated to 0x80
        sel = 1'b1;
        clear_init();
        m_init[0] = 'h680;
        m_init['h80] = 'h189; m_init['h81] = 'h28A; m_init['h82] = 'h38B;
        m_init['h83] = 'hE00; m_init['h84] = 'hF00;
        m_init['h89] = 'h010; m_init['h8A] = 'h014; m_init['h8B] = 'h018;
        run_and_check("wide_classic", 200);
        if (got.size() > 0) check("wide_classic value", {20'd0, got[0]}, 32'h0C);
        check("wide_classic cyc", r_cnt, 32'd29);

        // 0xFFF + 1 sets carry on the wide instance
        clear_init();
        m_init[0] = 'h110; m_init[1] = 'h211; m_init[2] = 'h704; m_init[3] = 'hF00;
        m_init[4] = 'hE00; m_init[5] = 'hF00; m_init['h10] = 'hFFF; m_init['h11] = 'h001;
        run_and_check("wide_carry", 200);
        check("wide_carry jc", {24'd0, o_pc}, 32'd6);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++)
                m_init[i] = ($urandom_range(0, 15) << 8) | $urandom_range(0, 255);
            run_and_check($sformatf("rand12_%0d", p), 400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
